// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if: host request/response and memory control signals (master drives wtake..ws, slave drives req..wdata)
interface ram_bus_master_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] len;
  logic [DEPTH-1:0] wdata;
  logic             wtake;
  logic [DEPTH-1:0] rdata;
  logic             rvalid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] adb;
  logic             oe;
  logic             cs;
  logic             ws;
  modport master (
    input  req, we, addr, len, wdata,
    output wtake, rdata, rvalid, busy, done, adb, oe, cs, ws
  );
  modport slave (
    output req, we, addr, len, wdata,
    input  wtake, rdata, rvalid, busy, done, adb, oe, cs, ws
  );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master: burst read/write master for an async SRAM (clk/rst, host+memory control via bus, bidirectional datab)
module ram_bus_master #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_bus_master_if.master     bus,
  inout  wire      [DEPTH-1:0] datab
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_SAMPLE, FIN} state_t;
  state_t           state, next;
  logic [WIDTH-1:0] addr_q, cnt;
  logic [DEPTH-1:0] dq, rdata_q;
  logic             rvalid_q, last, wr;
  assign last = cnt == '0;
  assign wr = state == W_SETUP || state == W_STROBE || state == W_HOLD;
  assign datab = wr ? dq : 'z;
  assign bus.adb = addr_q;
  assign bus.rdata = rdata_q;
  assign bus.rvalid = rvalid_q;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = bus.req ? (bus.we ? W_SETUP : R_SETUP) : IDLE;
      W_SETUP:  next = W_STROBE;
      W_STROBE: next = W_HOLD;
      W_HOLD:   next = last ? FIN : W_SETUP;
      R_SETUP:  next = R_SAMPLE;
      R_SAMPLE: next = last ? FIN : R_SETUP;
      default:  next = IDLE;
    endcase
    bus.oe = state == R_SETUP || state == R_SAMPLE;
    bus.cs = !wr;
    bus.ws = state == W_STROBE;
    bus.wtake = state == W_HOLD && !last;
    bus.busy = state != IDLE && state != FIN;
    bus.done = state == FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt <= '0;
      dq <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= state == R_SAMPLE;
      if (state == IDLE && bus.req) begin
        addr_q <= bus.addr;
        cnt <= bus.len;
        dq <= bus.wdata;
      end
      if (state == W_HOLD && !last) dq <= bus.wdata;
      if (state == R_SAMPLE) rdata_q <= datab;
      if ((state == W_HOLD || state == R_SAMPLE) && !last) begin
        addr_q <= addr_q + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: table, random and corner-case checks of ram_bus_master against an array memory model
module tb_ram_bus_master;
  localparam int DW = 8;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_bus_master_if #(.DEPTH(DW), .WIDTH(AW)) bus ();
  wire [DW-1:0] datab;
  ram_bus_master #(.DEPTH(DW), .WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus), .datab(datab));
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic p_rd = 1'b0;
  logic [AW-1:0] p_adb = '0;
  logic [AW-1:0] waddr_log [$];
  wire mem_drive = bus.oe && bus.cs && p_rd && p_adb == bus.adb;
  assign datab = mem_drive ? mem[bus.adb] : 'z;
  always @(posedge clk) begin
    p_rd <= bus.oe && bus.cs;
    p_adb <= bus.adb;
  end
  always @(posedge bus.ws) begin
    mem[bus.adb] <= datab;
    waddr_log.push_back(bus.adb);
  end
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.cs && !mem_drive) chk("datab_released", int'((|datab) === 1'b1), 0);
  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [AW-1:0] l;
    logic [DW-1:0] d [4];
    int            busy;
    int            wtk;
  } vec_t;
  int busy_n, wtake_n, done_n, rv_done, wbase;
  logic [DW-1:0] rd_q [$];
  task automatic run(input bit we, input logic [AW-1:0] a, input logic [AW-1:0] l,
                     input logic [DW-1:0] d [32], input bit hold);
    int k = 1;
    int cyc = 0;
    busy_n = 0; wtake_n = 0; done_n = 0; rv_done = 0; rd_q = {};
    wbase = waddr_log.size();
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.addr = a; bus.len = l; bus.wdata = d[0];
    @(negedge clk);
    if (!hold) bus.req = 1'b0;
    while (cyc < 300) begin
      if (bus.busy) busy_n++;
      if (bus.rvalid) rd_q.push_back(bus.rdata);
      if (bus.wtake) begin
        wtake_n++;
        bus.wdata = d[k % 32];
        k++;
      end
      if (bus.done) begin
        done_n++;
        rv_done = int'(bus.rvalid);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic verify(input string tag, input bit we, input logic [AW-1:0] a, input logic [AW-1:0] l,
                        input logic [DW-1:0] d [32], input int exp_busy, input int exp_wtk);
    int n = int'(l) + 1;
    chk({tag, "_busy"}, busy_n, exp_busy);
    chk({tag, "_wtake"}, wtake_n, exp_wtk);
    chk({tag, "_done"}, done_n, 1);
    if (we) begin
      chk({tag, "_ws_count"}, waddr_log.size() - wbase, n);
      for (int i = 0; i < n; i++) begin
        chk({tag, "_waddr"}, (wbase + i < waddr_log.size()) ? int'(waddr_log[wbase + i]) : -1, (int'(a) + i) % 32);
        ref_mem[(int'(a) + i) % 32] = d[i];
      end
    end else begin
      chk({tag, "_rvalid_count"}, rd_q.size(), n);
      chk({tag, "_rvalid_at_done"}, rv_done, 1);
      for (int i = 0; i < n; i++)
        chk({tag, "_rdata"}, (i < rd_q.size()) ? int'(rd_q[i]) : -1, int'(d[i]));
    end
  endtask
  initial begin
    vec_t tbl [4];
    logic [DW-1:0] dd [32];
    bit we;
    logic [AW-1:0] a, l;
    int cnt, base;
    tbl[0] = '{1'b1, 5'h03, 5'd0, '{8'hA5, 8'h00, 8'h00, 8'h00}, 3, 0};
    tbl[1] = '{1'b0, 5'h03, 5'd0, '{8'hA5, 8'h00, 8'h00, 8'h00}, 2, 0};
    tbl[2] = '{1'b1, 5'h1E, 5'd3, '{8'h11, 8'h22, 8'h33, 8'h44}, 12, 3};
    tbl[3] = '{1'b0, 5'h1E, 5'd3, '{8'h11, 8'h22, 8'h33, 8'h44}, 8, 0};
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.len = '0; bus.wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe", bus.oe, 0);
    chk("rst_cs", bus.cs, 1);
    chk("rst_ws", bus.ws, 0);
    chk("rst_adb", bus.adb, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_wtake", bus.wtake, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 32; j++) dd[j] = (j < 4) ? tbl[i].d[j] : '0;
      run(tbl[i].we, tbl[i].a, tbl[i].l, dd, 1'b0);
      verify($sformatf("tbl%0d", i), tbl[i].we, tbl[i].a, tbl[i].l, dd, tbl[i].busy, tbl[i].wtk);
    end
    for (int j = 0; j < 32; j++) dd[j] = DW'($urandom_range(1, 255));
    run(1'b1, 5'h00, 5'd31, dd, 1'b0);
    verify("fill", 1'b1, 5'h00, 5'd31, dd, 96, 31);
    for (int t = 0; t < 30; t++) begin
      we = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 31));
      l = AW'($urandom_range(0, 31));
      for (int j = 0; j < 32; j++)
        dd[j] = we ? DW'($urandom_range(1, 255)) : ref_mem[(int'(a) + j) % 32];
      run(we, a, l, dd, 1'b0);
      verify("rand", we, a, l, dd, (we ? 3 : 2) * (int'(l) + 1), we ? int'(l) : 0);
    end
    for (int j = 0; j < 32; j++) dd[j] = 8'h5A;
    run(1'b1, 5'h10, 5'd1, dd, 1'b1);
    verify("hold_first", 1'b1, 5'h10, 5'd1, dd, 6, 1);
    @(negedge clk);
    chk("hold_idle_busy", bus.busy, 0);
    chk("hold_idle_done", bus.done, 0);
    @(negedge clk);
    chk("hold_restart_busy", bus.busy, 1);
    bus.req = 1'b0;
    cnt = 1;
    while (!bus.done && cnt < 50) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("hold_second_busy", cnt, 6);
    chk("hold_second_done", bus.done, 1);
    dd[0] = 8'hAA; dd[1] = 8'hBB; dd[2] = 8'hCC; dd[3] = 8'hDD;
    base = waddr_log.size();
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 5'h08; bus.len = 5'd3; bus.wdata = dd[0];
    @(negedge clk);
    bus.req = 1'b0;
    cnt = 1;
    for (int c = 0; c < 100; c++) begin
      if (bus.ws && waddr_log.size() - base == 3) break;
      if (bus.wtake) begin
        bus.wdata = dd[cnt];
        cnt++;
      end
      @(negedge clk);
    end
    chk("abort_at_beat2_strobe", int'(bus.ws) + waddr_log.size() - base, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ws", bus.ws, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_cs", bus.cs, 1);
    chk("abort_oe", bus.oe, 0);
    chk("abort_adb", bus.adb, 0);
    chk("abort_rdata", bus.rdata, 0);
    rst = 1'b0;
    ref_mem[8] = 8'hAA; ref_mem[9] = 8'hBB; ref_mem[10] = 8'hCC;
    for (int j = 0; j < 32; j++) dd[j] = ref_mem[(8 + j) % 32];
    run(1'b0, 5'h08, 5'd3, dd, 1'b0);
    verify("abort_readback", 1'b0, 5'h08, 5'd3, dd, 8, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
